fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the 4096x16 instruction memory.
- Owns the fetch PC and drives the memory address. Memory read is combinational and same-cycle.
- Captures each fetched instruction with its PC into a 2-entry prefetch queue, and presents it to decode with a valid/ready handshake.
- Handles start, branch redirect/flush, and stop on a HALT opcode.

Parameters:
ADDR_W, 12, instruction address width (memory depth 2^ADDR_W)
INST_W, 16, instruction width
HALT_OP, 4'b1111, opcode (inst[15:12]) that stops fetching

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse: begin fetching at start_pc (honoured only in IDLE)
start_pc  in  ADDR_W  initial fetch address
mem_addr  out  ADDR_W  address to instruction memory (= fetch PC register)
mem_inst  in  INST_W  instruction read at mem_addr, same cycle
dec_valid  out  1  queue head valid
dec_inst  out  INST_W  queue head instruction
dec_pc  out  ADDR_W  PC of queue head
dec_ready  in  1  decode accepts head this cycle
redirect  in  1  branch taken: flush queue, refetch from redirect_pc
redirect_pc  in  ADDR_W  branch target
halted  out  1  high in HALTED state
busy  out  1  high in RUN state

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-run):
  - state=IDLE, fpc=0, queue empty.
  - dec_valid=0, dec_inst=0, dec_pc=0, halted=0, busy=0, mem_addr=0.
- States:
  - IDLE: no fetch. start=1 -> fpc<=start_pc, go RUN. redirect in IDLE is ignored.
  - RUN: fetch is permitted each cycle.
  - HALTED: no fetch. The queue still drains to decode. redirect=1 -> flush, fpc<=redirect_pc, go RUN. start is ignored.
- Push condition (RUN only): push = !redirect && (count<2 || (count==2 && dec_valid && dec_ready)).
  - On push: enqueue {fpc, mem_inst}; fpc<=fpc+1, modulo 2^ADDR_W (4095 -> 0).
  - No push: fpc holds.
- HALT:
  - If a pushed mem_inst[15:12]==HALT_OP, the HALT word is still enqueued.
  - The state goes HALTED next cycle. fpc still advances to the following address.
- Pop: dec_valid && dec_ready removes the head at the clock edge.
  - Simultaneous push and pop at count=2 or count=1 is legal; count is unchanged.
- Queue outputs:
  - dec_valid = (count!=0).
  - dec_inst/dec_pc show the head entry directly from registers, with no combinational path from mem_inst.
  - When count==0, dec_inst/dec_pc hold their last values; decode must not use them.
- Redirect (RUN or HALTED) has highest priority after reset:
  - Flush queue (count<=0); the current head is not consumed even if dec_ready=1.
  - No push; fpc<=redirect_pc; state<=RUN.
  - dec_valid=0 in the cycle after redirect. The first target instruction is valid two cycles after redirect.
- Latency:
  - start at edge N -> mem_addr=start_pc after N.
  - Entry pushed at edge N+1 -> dec_valid=1 after N+1.
  - Steady state with dec_ready held high: one instruction per cycle.
- Backpressure: dec_ready=0 with count==2 -> no push, and fpc/mem_addr hold stable.
- Outputs: busy=(state==RUN), halted=(state==HALTED); both registered-state decodes.

Test Plan:
1. Reset then start=1, start_pc=0, memory {0:6142h, 1:6243h, 2:2324h, 3:F000h}, dec_ready=1.
   - Required: dec_pc 0,1,2,3 on consecutive cycles with matching dec_inst.
   - Required: halted=1 the cycle after 3 is pushed; no entry for PC 4 ever appears.
2. Backpressure: run from 0 with dec_ready=0.
   - Required: count fills to 2 (PC 0,1); mem_addr holds at 2.
   - Then raise dec_ready: PC 0,1,2 follow back-to-back with no bubble.
3. Redirect with queue full (PC 5,6 queued), redirect=1, redirect_pc=100h, dec_ready=1.
   - Required: 5 is not consumed; dec_valid=0 next cycle; following valid entry is dec_pc=100h.
4. Wrap: start_pc=FFEh, dec_ready=1.
   - Required: dec_pc FFEh, FFFh, 000h, 001h.
5. HALTED exit: after halt in scenario 1, redirect_pc=002h.
   - Required: busy=1, halted=0, and fetch resumes with dec_pc=2.
   - Separately, start=1 while HALTED is ignored.
6. Reset mid-run: assert reset with count=2.
   - Required: next cycle dec_valid=0, mem_addr=0, busy=0.
   - No fetch occurs until start.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_sequencer                                              |
// | Description : Fetch PC owner and 2-entry prefetch queue feeding decode,     |
// |               with start, branch redirect/flush and HALT-opcode stop.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
    parameter int         ADDR_W  = 12,
    parameter int         INST_W  = 16,
    parameter logic [3:0] HALT_OP = 4'b1111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_inst,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              dec_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_fpc;
    logic [1:0]        r_count;
    logic [INST_W-1:0] r_q_inst [0:1];
    logic [ADDR_W-1:0] r_q_pc   [0:1];

    logic w_pop;
    logic w_push;
    logic w_flush;
    logic w_is_halt;
    logic w_wr_slot;

    assign w_pop     = dec_valid && dec_ready;
    assign w_flush   = redirect && (r_state != S_IDLE);
    assign w_is_halt = (mem_inst[INST_W-1 -: 4] == HALT_OP);
    assign w_push    = (r_state == S_RUN) && !redirect &&
                       ((r_count < 2'd2) || ((r_count == 2'd2) && w_pop));
    // Slot the new entry lands in, after any same-cycle pop has shifted the queue.
    assign w_wr_slot = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!redirect && w_push && w_is_halt) begin
                    w_state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                if (redirect) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_fpc <= start_pc;
        end else if (w_flush) begin
            r_fpc <= redirect_pc;
        end else if (w_push) begin
            r_fpc <= r_fpc + ADDR_W'(1);
        end
    end

    // Entry 0 is always the head; it is left untouched when the queue empties
    // so dec_inst/dec_pc hold their last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= 2'd0;
            r_q_inst[0] <= '0;
            r_q_inst[1] <= '0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
        end else if (w_flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop && (r_count == 2'd2)) begin
                r_q_inst[0] <= r_q_inst[1];
                r_q_pc[0]   <= r_q_pc[1];
            end
            if (w_push) begin
                if (w_wr_slot) begin
                    r_q_inst[1] <= mem_inst;
                    r_q_pc[1]   <= r_fpc;
                end else begin
                    r_q_inst[0] <= mem_inst;
                    r_q_pc[0]   <= r_fpc;
                end
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign mem_addr  = r_fpc;
    assign dec_valid = (r_count != 2'd0);
    assign dec_inst  = r_q_inst[0];
    assign dec_pc    = r_q_pc[0];
    assign busy      = (r_state == S_RUN);
    assign halted    = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_sequencer                                           |
// | Description : Queue-based reference model, directed scenarios and random   |
// |               traffic for fetch_sequencer.                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

    localparam int ADDR_W = 12;
    localparam int INST_W = 16;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_inst;
    logic              dec_valid;
    logic [INST_W-1:0] dec_inst;
    logic [ADDR_W-1:0] dec_pc;
    logic              dec_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;
    logic              busy;

    logic [INST_W-1:0] mem [0:4095];
    assign mem_inst = mem[mem_addr];

    fetch_sequencer #(.ADDR_W(ADDR_W), .INST_W(INST_W), .HALT_OP(4'b1111)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_pc   (start_pc),
        .mem_addr   (mem_addr),
        .mem_inst   (mem_inst),
        .dec_valid  (dec_valid),
        .dec_inst   (dec_inst),
        .dec_pc     (dec_pc),
        .dec_ready  (dec_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    ent_t              q[$];
    int                m_mode;
    logic [ADDR_W-1:0] m_pc;
    int                vectors;
    int                miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Next-cycle behaviour derived from the queue/PC rules, applied at each edge.
    task automatic model_update();
        int n;
        bit pop;
        bit can_push;
        n   = q.size();
        pop = (n > 0) && dec_ready;
        if (reset) begin
            m_mode = M_IDLE;
            m_pc   = '0;
            q.delete();
        end else if (redirect && m_mode != M_IDLE) begin
            q.delete();
            m_pc   = redirect_pc;
            m_mode = M_RUN;
        end else if (m_mode == M_IDLE) begin
            if (start) begin
                m_pc   = start_pc;
                m_mode = M_RUN;
            end
        end else begin
            can_push = (m_mode == M_RUN) && (n < 2 || (n == 2 && pop));
            if (pop) void'(q.pop_front());
            if (can_push) begin
                q.push_back('{pc: m_pc, inst: mem[m_pc]});
                if (mem[m_pc][15:12] == 4'hF) m_mode = M_HALT;
                m_pc = m_pc + 12'd1;
            end
        end
    endtask

    task automatic compare();
        chk("dec_valid", 32'(dec_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("dec_pc", 32'(dec_pc), 32'(q[0].pc));
            chk("dec_inst", 32'(dec_inst), 32'(q[0].inst));
        end
        chk("mem_addr", 32'(mem_addr), 32'(m_pc));
        chk("busy", 32'(busy), 32'(m_mode == M_RUN));
        chk("halted", 32'(halted), 32'(m_mode == M_HALT));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [INST_W-1:0] s1_prog [0:3];

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_mode      = M_IDLE;
        m_pc        = '0;
        reset       = 1'b1;
        start       = 1'b0;
        start_pc    = '0;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        for (int i = 0; i < 4096; i++)
            mem[i] = 16'(($urandom_range(0, 14) << 12) | $urandom_range(0, 4095));
        s1_prog[0] = 16'h6142;
        s1_prog[1] = 16'h6243;
        s1_prog[2] = 16'h2324;
        s1_prog[3] = 16'hF000;
        for (int i = 0; i < 4; i++) mem[i] = s1_prog[i];

        // Reset state
        step();
        reset = 1'b0;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_inst", 32'(dec_inst), 32'd0);
        chk("rst_dec_pc", 32'(dec_pc), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Straight-line program ending in HALT
        start = 1'b1; start_pc = 12'h000; dec_ready = 1'b1;
        step();
        start = 1'b0;
        chk("s1_mem_addr", 32'(mem_addr), 32'h0);
        chk("s1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s1_dec_pc", 32'(dec_pc), 32'(k));
            chk("s1_dec_inst", 32'(dec_inst), 32'(s1_prog[k]));
        end
        chk("s1_halted", 32'(halted), 32'd1);
        step();
        step();
        chk("s1_no_pc4", 32'(dec_valid), 32'd0);
        chk("s1_fpc_after_halt", 32'(mem_addr), 32'h4);

        // Leave HALTED via redirect; start while HALTED is ignored
        redirect = 1'b1; redirect_pc = 12'h002;
        step();
        redirect = 1'b0;
        chk("s5_busy", 32'(busy), 32'd1);
        chk("s5_halted", 32'(halted), 32'd0);
        chk("s5_gap", 32'(dec_valid), 32'd0);
        step();
        chk("s5_dec_pc", 32'(dec_pc), 32'h2);
        for (int k = 0; k < 3; k++) step();
        start = 1'b1; start_pc = 12'h040;
        step();
        start = 1'b0;
        chk("s5_start_ign_halted", 32'(halted), 32'd1);
        chk("s5_start_ign_addr", 32'(mem_addr), 32'h4);

        // Backpressure
        do_reset();
        start = 1'b1; start_pc = 12'h000; dec_ready = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("s2_hold_addr", 32'(mem_addr), 32'h2);
        chk("s2_head", 32'(dec_pc), 32'h0);
        dec_ready = 1'b1;
        step();
        chk("s2_next1", 32'(dec_pc), 32'h1);
        step();
        chk("s2_next2", 32'(dec_pc), 32'h2);

        // Redirect with queue full
        do_reset();
        start = 1'b1; start_pc = 12'h005; dec_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        chk("s3_head5", 32'(dec_pc), 32'h5);
        redirect = 1'b1; redirect_pc = 12'h100; dec_ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("s3_flush", 32'(dec_valid), 32'd0);
        step();
        chk("s3_target_valid", 32'(dec_valid), 32'd1);
        chk("s3_target_pc", 32'(dec_pc), 32'h100);

        // Address wrap
        do_reset();
        start = 1'b1; start_pc = 12'hFFE; dec_ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s4_wrap_pc", 32'(dec_pc), 32'((12'hFFE + k) & 12'hFFF));
        end

        // Reset mid-run with a full queue
        do_reset();
        start = 1'b1; start_pc = 12'h010; dec_ready = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        do_reset();
        chk("s6_valid", 32'(dec_valid), 32'd0);
        chk("s6_addr", 32'(mem_addr), 32'h0);
        chk("s6_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) step();
        chk("s6_no_fetch", 32'(mem_addr), 32'h0);

        // Random traffic
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            start       = ($urandom_range(0, 7) == 0);
            start_pc    = 12'($urandom);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = 12'($urandom);
            dec_ready   = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
